wiredor_req_responder: RTL
==========================

# wiredor_req_responder

Interconnect-side responder for the 32-core wired-OR request bus. It samples every core's request line, grants one core at a time in round-robin order, and returns a fixed-latency acknowledge pulse. It holds the grant until the requester drops its request. It also drives a registered all-idle indication that the test environment uses to decide when outstanding traffic has drained.

## Interface

**Parameters**
- `NUM_CORES`, default 32: number of request/grant lanes; legal range 2..32.
- `RESP_LAT`, default 2: cycles from grant rise to acknowledge pulse; legal range 1..15.
- `TIMEOUT`, default 64: maximum number of cycles a core may hold its request after acknowledge. Used only with the macro in Configuration.

**Ports**
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `core_req`, input, `NUM_CORES`: level request from each core; bit i corresponds to Core i.
- `core_gnt`, output, `NUM_CORES`: one-hot-or-zero grant, registered.
- `core_ack`, output, `NUM_CORES`: one-cycle acknowledge pulse to the granted core, registered.
- `bus_busy`, output, 1: high whenever the FSM is not in IDLE.
- `all_idle`, output, 1: registered; high when `core_req` is all zeros and the FSM is in IDLE.
- `timeout_err`, output, 1: sticky error flag; present only with the macro in Configuration.

## Operation

**FSM states:** IDLE, GRANT, RELEASE.

**IDLE**
- If any `core_req` bit is high, select the winner by round-robin.
- The search starts at `rr_ptr` and wraps modulo `NUM_CORES`.
- Load `core_gnt` one-hot for the winner, clear the latency counter, and go to GRANT.

**GRANT**
- The latency counter increments every cycle.
- When the count reaches `RESP_LAT`, `core_ack[winner]` pulses high for exactly one cycle and the FSM goes to RELEASE.
- If the winner drops its request during GRANT, it is ignored: the ack is still issued and the full handshake completes.

**RELEASE**
- Wait until `core_req[winner]` is sampled low.
- Then clear `core_gnt`, set `rr_ptr` to (winner+1) mod `NUM_CORES`, and return to IDLE.

**General rules**
- Requests from non-granted cores are held pending; nothing is queued beyond the level of the request lines.
- `all_idle` is the registered value of (FSM==IDLE && `core_req`==0).
- **Reset** forces IDLE and `rr_ptr`=0, and clears the counter.
- **Reset mid-operation** aborts the handshake with no ack; the core must re-request.
- **Simultaneous requests:** the highest priority goes to the lowest index at or above `rr_ptr`, then wrapping.
- **Single requester:** it is regranted repeatedly with no starvation penalty.

## Timing

**Reset values:** `core_gnt`=0, `core_ack`=0, `bus_busy`=0, `all_idle`=0 (it becomes valid one cycle after reset deasserts), `timeout_err`=0.

**Handshake latencies**
- `core_req` sampled high at edge t → `core_gnt` high from edge t+1.
- Ack is high during cycle t+1+`RESP_LAT`.
- Request seen low at edge r → `core_gnt` low from edge r+1.
- Earliest next grant is at edge r+2, so there is at least one IDLE cycle between grants.

**Request/grant rules**
- A request that rises while another core is granted is served only after that grant is released.
- `core_ack` and `core_gnt` are never nonzero on a lane that is not the winner.

## Configuration

**Macro:** `WIREDOR_TIMEOUT_EN`

**Defined**
- In RELEASE, a counter runs from ack onward.
- If the winner still holds its request after `TIMEOUT` cycles, the grant is forcibly cleared and `rr_ptr` advances.
- `timeout_err` is set and stays set until reset.
- The stuck core is treated as a new request on a later round.

**Undefined**
- RELEASE waits indefinitely.
- The `timeout_err` port and its counter do not exist.

## Test plan

- **Reset, then one requester:** after reset, raise `core_req[5]` at cycle 10 with `RESP_LAT`=2.
  - `core_gnt`=0x20 from cycle 11; `core_ack[5]` pulses at cycle 13.
  - Drop the request at cycle 15 → gnt 0 at cycle 16; `all_idle`=1 at cycle 17.
- **Simultaneous requests:** raise requests 0, 3 and 31 together with `rr_ptr`=0.
  - Grant order is 0, 3, 31, each with exactly one ack.
  - After 31 releases, `rr_ptr` wraps to 0.
- **Round-robin fairness:** hold requests 7 and 8 continuously, releasing each after ack.
  - Grants alternate 7, 8, 7, 8; neither lane is granted twice in a row.
- **Early drop:** core 2 drops its request one cycle after grant.
  - The ack still pulses at grant+`RESP_LAT`; gnt clears the cycle after the ack cycle.
- **Reset mid-handshake:** assert `rst` during GRANT for core 9.
  - No ack is issued; all outputs are 0 the next cycle; a re-request is granted normally.
- **Timeout (`WIREDOR_TIMEOUT_EN` defined, `TIMEOUT`=4):** core 12 holds its request after ack.
  - Gnt clears 4 cycles after the ack and `timeout_err`=1.
  - A pending request from core 13 is granted next.

Source files
------------

// File: rtl/wiredor_req_responder.sv
// rtl/wiredor_req_responder.sv - round-robin grant/ack responder for the wired-OR request bus
// Optional release watchdog and sticky timeout_err enabled by WIREDOR_TIMEOUT_EN.
module wiredor_req_responder #(
  parameter int NUM_CORES = 32,
  parameter int RESP_LAT  = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] core_req,
  output logic [NUM_CORES-1:0] core_gnt,
  output logic [NUM_CORES-1:0] core_ack,
  output logic                 bus_busy,
  output logic                 all_idle
`ifdef WIREDOR_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int WW = $clog2(NUM_CORES);

  if (NUM_CORES < 2 || NUM_CORES > 32 || RESP_LAT < 1 || RESP_LAT > 15 || TIMEOUT < 1) begin : g_param_check
    $error("wiredor_req_responder: parameter out of legal range");
  end

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [WW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]        win_q, win_d;
  logic [3:0]           lat_cnt_q, lat_cnt_d;
  logic [NUM_CORES-1:0] gnt_d, ack_d;
  logic [WW-1:0]        rr_win;
  logic [WW-1:0]        ptr_after;
  logic [WW:0]          idx;
  logic                 found;
  logic                 holder_req;

`ifdef WIREDOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_d;
`endif

  // First requesting lane at or above rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    found  = 1'b0;
    rr_win = '0;
    idx    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = {1'b0, rr_ptr_q} + (WW+1)'(i);
      if (idx >= (WW+1)'(NUM_CORES)) idx = idx - (WW+1)'(NUM_CORES);
      if (!found && core_req[idx[WW-1:0]]) begin
        found  = 1'b1;
        rr_win = idx[WW-1:0];
      end
    end
  end

  assign ptr_after  = (win_q == WW'(NUM_CORES - 1)) ? '0 : win_q + WW'(1);
  assign holder_req = |(core_req & core_gnt);
  assign bus_busy   = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    gnt_d     = core_gnt;
    ack_d     = '0;
    lat_cnt_d = lat_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
`ifdef WIREDOR_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    err_d     = timeout_err;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = GRANT;
          win_d     = rr_win;
          gnt_d     = NUM_CORES'(1) << rr_win;
          lat_cnt_d = '0;
        end
      end
      GRANT: begin
        // The request level is ignored here; the ack always completes.
        lat_cnt_d = lat_cnt_q + 4'd1;
        if (lat_cnt_q == 4'(RESP_LAT - 1)) begin
          ack_d   = core_gnt;
          state_d = RELEASE;
`ifdef WIREDOR_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      RELEASE: begin
        if (!holder_req) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = ptr_after;
        end
`ifdef WIREDOR_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = ptr_after;
          err_d    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      core_gnt  <= '0;
      core_ack  <= '0;
      lat_cnt_q <= '0;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      all_idle  <= 1'b0;
`ifdef WIREDOR_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      core_gnt  <= gnt_d;
      core_ack  <= ack_d;
      lat_cnt_q <= lat_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      all_idle  <= (state_q == IDLE) && (core_req == '0);
`ifdef WIREDOR_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      timeout_err <= err_d;
`endif
    end
  end

endmodule
